// File: rtl/vga_timing_if.sv
// Display-timing bundle produced by the VGA timing generator.
// It carries the sync pulses, the visible-area flag, the current scan
// coordinates and the pixel/frame strobes to the drawing stage.
interface vga_timing_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       pixel_tick;
    logic       frame_end;

    // The timing generator drives the bundle.
    modport master (
        output hsync,
        output vsync,
        output video_on,
        output pixel_x,
        output pixel_y,
        output pixel_tick,
        output frame_end
    );

    // Downstream consumers only observe the bundle.
    modport slave (
        input hsync,
        input vsync,
        input video_on,
        input pixel_x,
        input pixel_y,
        input pixel_tick,
        input frame_end
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider and VGA scan timing generator (640x480@60 by default).
// Every output is a register whose next value is decoded from the next
// counter values, so sync, video_on, pixel_tick and frame_end always agree
// with the coordinates presented in the same clk and cannot glitch.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master vga
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);

    // With a divide-by-one the pixel enable is permanently asserted,
    // including while reset is held.
    localparam logic TICK_RESET = (CLK_DIV == 1);

    logic [DIV_W-1:0] div_reg, div_next;
    logic             tick_reg, tick_next;
    logic [9:0]       h_reg, h_next;
    logic [9:0]       v_reg, v_next;
    logic             hsync_reg, hsync_next;
    logic             vsync_reg, vsync_next;
    logic             video_reg, video_next;
    logic             frame_end_reg, frame_end_next;
    logic             h_last;
    logic             v_last;

    // Next-state for the divider and the scan counters.  The counters move
    // on edges where the currently presented pixel_tick is high.
    always_comb begin
        div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
        tick_next = (div_next == DIV_LAST);

        h_last = (h_reg == H_LAST);
        v_last = (v_reg == V_LAST);

        h_next = h_reg;
        v_next = v_reg;
        if (tick_reg) begin
            h_next = h_last ? 10'd0 : h_reg + 10'd1;
            if (h_last) begin
                v_next = v_last ? 10'd0 : v_reg + 10'd1;
            end
        end
    end

    // Output decode from the next counts so the registered flags line up
    // with the registered coordinates.
    always_comb begin
        hsync_next = !((h_next >= H_SYNC_START) && (h_next <= H_SYNC_END));
        vsync_next = !((v_next >= V_SYNC_START) && (v_next <= V_SYNC_END));
        video_next = (h_next < H_VIS) && (v_next < V_VIS);
        frame_end_next = tick_next && (h_next == H_LAST) && (v_next == V_LAST);
    end

    // State and output registers; reset parks the scan at the top-left pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg       <= '0;
            tick_reg      <= TICK_RESET;
            h_reg         <= 10'd0;
            v_reg         <= 10'd0;
            hsync_reg     <= 1'b1;
            vsync_reg     <= 1'b1;
            video_reg     <= 1'b1;
            frame_end_reg <= 1'b0;
        end else begin
            div_reg       <= div_next;
            tick_reg      <= tick_next;
            h_reg         <= h_next;
            v_reg         <= v_next;
            hsync_reg     <= hsync_next;
            vsync_reg     <= vsync_next;
            video_reg     <= video_next;
            frame_end_reg <= frame_end_next;
        end
    end

    assign vga.hsync      = hsync_reg;
    assign vga.vsync      = vsync_reg;
    assign vga.video_on   = video_reg;
    assign vga.pixel_x    = h_reg;
    assign vga.pixel_y    = v_reg;
    assign vga.pixel_tick = tick_reg;
    assign vga.frame_end  = frame_end_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen.  Instance a uses the full 640x480
// timing at CLK_DIV=4 (reset, cadence, line-0 horizontal timing); instances
// b and c use a reduced 20x13 raster so whole frames fit in a short run
// (b at CLK_DIV=4, c at CLK_DIV=1).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_if vga_a ();
    vga_timing_if vga_b ();
    vga_timing_if vga_c ();

    vga_timing_gen dut_a (
        .clk   (clk),
        .reset (reset),
        .vga   (vga_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
        .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(4)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .vga   (vga_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
        .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(1)
    ) dut_c (
        .clk   (clk),
        .reset (reset),
        .vga   (vga_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clk and sample 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decode formulas for the full-size raster.
    function automatic logic bad_a();
        logic hs, vs, von;
        hs  = !((vga_a.pixel_x >= 656) && (vga_a.pixel_x <= 751));
        vs  = !((vga_a.pixel_y >= 490) && (vga_a.pixel_y <= 491));
        von = (vga_a.pixel_x < 640) && (vga_a.pixel_y < 480);
        return (vga_a.hsync !== hs) || (vga_a.vsync !== vs) || (vga_a.video_on !== von);
    endfunction

    // Decode formulas for the reduced raster: hsync low x=12..14,
    // vsync low y=8..9, visible x<10 and y<6.
    function automatic logic bad_b();
        logic hs, vs, von;
        hs  = !((vga_b.pixel_x >= 12) && (vga_b.pixel_x <= 14));
        vs  = !((vga_b.pixel_y >= 8) && (vga_b.pixel_y <= 9));
        von = (vga_b.pixel_x < 10) && (vga_b.pixel_y < 6);
        return (vga_b.hsync !== hs) || (vga_b.vsync !== vs) || (vga_b.video_on !== von);
    endfunction

    initial begin
        int ticks, last_tick, spacing_bad, x_bad;
        int prev_x, prev_y, prev_tick, prev_von, prev_hs;
        int von_fall_x, von_fall_prev, hs_fall_x, hs_rise_x, hs_low;
        int wrap_seen, wrap_y, wrap_prev_y, cons_bad;
        int n, fe_clks, vs_low, vs_bad, von_bad, tick_low;

        // ---- reset state while reset is held ----
        repeat (3) step();
        chk("rst_a_x", vga_a.pixel_x, 0);
        chk("rst_a_y", vga_a.pixel_y, 0);
        chk("rst_a_hsync", vga_a.hsync, 1);
        chk("rst_a_vsync", vga_a.vsync, 1);
        chk("rst_a_video_on", vga_a.video_on, 1);
        chk("rst_a_tick", vga_a.pixel_tick, 0);
        chk("rst_a_frame_end", vga_a.frame_end, 0);
        chk("rst_c_tick", vga_c.pixel_tick, 1);

        // ---- first tick after release ----
        reset = 1'b0;
        step();
        chk("rel_e1_tick", vga_a.pixel_tick, 0);
        chk("rel_e1_c_x", vga_c.pixel_x, 1);
        step();
        chk("rel_e2_tick", vga_a.pixel_tick, 0);
        step();
        chk("rel_e3_tick", vga_a.pixel_tick, 1);
        chk("rel_e3_x", vga_a.pixel_x, 0);
        step();
        chk("rel_e4_x", vga_a.pixel_x, 1);
        chk("rel_e4_tick", vga_a.pixel_tick, 0);

        // ---- tick cadence over 40 clks ----
        ticks = 0; last_tick = -1; spacing_bad = 0; x_bad = 0;
        prev_x = int'(vga_a.pixel_x);
        prev_tick = int'(vga_a.pixel_tick);
        for (int i = 0; i < 40; i++) begin
            step();
            if (vga_a.pixel_tick) begin
                if (last_tick >= 0 && (i - last_tick) != 4) spacing_bad++;
                last_tick = i;
                ticks++;
            end
            if (int'(vga_a.pixel_x) != prev_x + prev_tick) x_bad++;
            prev_x = int'(vga_a.pixel_x);
            prev_tick = int'(vga_a.pixel_tick);
        end
        chk("cad_ticks", ticks, 10);
        chk("cad_spacing", spacing_bad, 0);
        chk("cad_x_step", x_bad, 0);

        // ---- horizontal timing across the rest of line 0 ----
        von_fall_x = 9999; von_fall_prev = 9999; hs_fall_x = 9999; hs_rise_x = 9999;
        hs_low = 0; wrap_seen = 0; wrap_y = 9999; wrap_prev_y = 9999; cons_bad = 0;
        prev_x = int'(vga_a.pixel_x);
        prev_y = int'(vga_a.pixel_y);
        prev_von = int'(vga_a.video_on);
        prev_hs = int'(vga_a.hsync);
        for (int i = 0; i < 3400 && wrap_seen == 0; i++) begin
            step();
            if (bad_a()) cons_bad++;
            if (prev_von == 1 && !vga_a.video_on) begin
                von_fall_x = int'(vga_a.pixel_x);
                von_fall_prev = prev_x;
            end
            if (prev_hs == 1 && !vga_a.hsync) hs_fall_x = int'(vga_a.pixel_x);
            if (prev_hs == 0 && vga_a.hsync) hs_rise_x = int'(vga_a.pixel_x);
            if (prev_x == 799 && vga_a.pixel_x == 10'd0) begin
                wrap_seen = 1;
                wrap_y = int'(vga_a.pixel_y);
                wrap_prev_y = prev_y;
            end else if (!vga_a.hsync) begin
                hs_low++;
            end
            prev_x = int'(vga_a.pixel_x);
            prev_y = int'(vga_a.pixel_y);
            prev_von = int'(vga_a.video_on);
            prev_hs = int'(vga_a.hsync);
        end
        chk("h_von_fall_x", von_fall_x, 640);
        chk("h_von_fall_prev_x", von_fall_prev, 639);
        chk("h_hsync_fall_x", hs_fall_x, 656);
        chk("h_hsync_rise_x", hs_rise_x, 752);
        chk("h_hsync_low_clks", hs_low, 384);
        chk("h_wrap_seen", wrap_seen, 1);
        chk("h_wrap_y", wrap_y, 1);
        chk("h_wrap_prev_y", wrap_prev_y, 0);
        chk("h_decode_a", cons_bad, 0);

        // ---- reduced raster, CLK_DIV=4: one full frame ----
        n = 0;
        while (!vga_b.frame_end && n < 2000) begin
            step();
            n++;
        end
        chk("b_fe_found", vga_b.frame_end, 1);
        chk("b_fe_at_x", vga_b.pixel_x, 19);
        chk("b_fe_at_y", vga_b.pixel_y, 12);
        chk("b_fe_with_tick", vga_b.pixel_tick, 1);
        step();
        fe_clks = 1;
        chk("b_after_fe_x", vga_b.pixel_x, 0);
        chk("b_after_fe_y", vga_b.pixel_y, 0);
        chk("b_fe_one_clk", vga_b.frame_end, 0);
        cons_bad = 0; vs_low = 0; vs_bad = 0; von_bad = 0;
        for (int i = 0; i < 1200; i++) begin
            if (bad_b()) cons_bad++;
            if (!vga_b.vsync) begin
                vs_low++;
                if (vga_b.pixel_y < 8 || vga_b.pixel_y > 9) vs_bad++;
            end
            if (vga_b.pixel_y >= 6 && vga_b.video_on) von_bad++;
            step();
            fe_clks++;
            if (vga_b.frame_end) break;
        end
        chk("b_frame_clks", fe_clks, 1040);
        chk("b_fe2_at_x", vga_b.pixel_x, 19);
        chk("b_fe2_at_y", vga_b.pixel_y, 12);
        chk("b_decode", cons_bad, 0);
        chk("b_vsync_lines", vs_bad, 0);
        chk("b_vsync_low_clks", vs_low, 160);
        chk("b_von_blank_lines", von_bad, 0);

        // ---- reduced raster, CLK_DIV=1: frame length and constant tick ----
        n = 0;
        while (!vga_c.frame_end && n < 400) begin
            step();
            n++;
        end
        chk("c_fe_found", vga_c.frame_end, 1);
        fe_clks = 0; tick_low = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            fe_clks++;
            if (!vga_c.pixel_tick) tick_low++;
            if (vga_c.frame_end) break;
        end
        chk("c_frame_clks", fe_clks, 260);
        chk("c_tick_always", tick_low, 0);

        // ---- asynchronous reset mid-frame on b at (13, 8) ----
        n = 0;
        while (!(vga_b.pixel_x == 10'd13 && vga_b.pixel_y == 10'd8) && n < 1200) begin
            step();
            n++;
        end
        chk("b_pre_rst_x", vga_b.pixel_x, 13);
        chk("b_pre_rst_hsync", vga_b.hsync, 0);
        chk("b_pre_rst_vsync", vga_b.vsync, 0);
        chk("b_pre_rst_video_on", vga_b.video_on, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("b_async_x", vga_b.pixel_x, 0);
        chk("b_async_y", vga_b.pixel_y, 0);
        chk("b_async_hsync", vga_b.hsync, 1);
        chk("b_async_vsync", vga_b.vsync, 1);
        chk("b_async_video_on", vga_b.video_on, 1);
        chk("b_async_tick", vga_b.pixel_tick, 0);
        step();
        reset = 1'b0;
        step();
        chk("b_rel_e1_tick", vga_b.pixel_tick, 0);
        step();
        chk("b_rel_e2_tick", vga_b.pixel_tick, 0);
        step();
        chk("b_rel_e3_tick", vga_b.pixel_tick, 1);
        chk("b_rel_e3_x", vga_b.pixel_x, 0);
        step();
        chk("b_rel_e4_x", vga_b.pixel_x, 1);

        // ---- asynchronous reset mid-line on a at x=700 ----
        n = 0;
        while (vga_a.pixel_x != 10'd700 && n < 3200) begin
            step();
            n++;
        end
        chk("a_pre_rst_x", vga_a.pixel_x, 700);
        chk("a_pre_rst_hsync", vga_a.hsync, 0);
        chk("a_pre_rst_video_on", vga_a.video_on, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("a_async_x", vga_a.pixel_x, 0);
        chk("a_async_y", vga_a.pixel_y, 0);
        chk("a_async_hsync", vga_a.hsync, 1);
        chk("a_async_video_on", vga_a.video_on, 1);
        chk("a_async_frame_end", vga_a.frame_end, 0);
        step();
        reset = 1'b0;
        repeat (4) step();
        chk("a_rel2_e4_x", vga_a.pixel_x, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-clock divider and 640x480@60 Hz VGA timing generator at the head of the display pipeline. Derives the 25 MHz pixel enable from the 100 MHz system clock and runs the horizontal and vertical scan counters. Produces active-low hsync/vsync, the video_on window and the current pixel coordinates consumed by the frame/text drawing stage. Also produces a one-cycle end-of-frame strobe so downstream blocks can latch per-frame state.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, system clocks per pixel; legal range is 1 or more

- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high; clears all state
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while (pixel_x, pixel_y) is inside the visible area
- pixel_x  out  10  horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  vertical count, 0..V_TOTAL-1
- pixel_tick  out  1  pixel enable, high for one clk in every CLK_DIV clks
- frame_end  out  1  one-clk strobe on the last pixel of a frame

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Divider: div counter runs 0..CLK_DIV-1 and increments every clk, then wraps.
  - pixel_tick = (div == CLK_DIV-1).
  - If CLK_DIV = 1, pixel_tick is constantly 1.
- h counter: advances only on edges where pixel_tick = 1. It wraps from H_TOTAL-1 to 0.
- v counter: advances only on edges where pixel_tick = 1 and h = H_TOTAL-1. It wraps from V_TOTAL-1 to 0.
- pixel_x = h counter; pixel_y = v counter.
- hsync is low iff H_ACTIVE+H_FP ≤ h ≤ H_ACTIVE+H_FP+H_SYNC-1, i.e. h = 656..751.
- vsync is low iff V_ACTIVE+V_FP ≤ v ≤ V_ACTIVE+V_FP+V_SYNC-1, i.e. v = 490..491.
- video_on = (h < H_ACTIVE) && (v < V_ACTIVE).
- hsync, vsync and video_on are registered. They are decoded from the next-count values, so on every cycle they match the pixel_x/pixel_y currently presented. They must be glitch-free.
- frame_end = pixel_tick && h = H_TOTAL-1 && v = V_TOTAL-1.
- Simultaneous wrap: when h and v wrap on the same edge, both go to 0 together. pixel_y never shows V_TOTAL.
- No other inputs exist; the block is free-running after reset.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - div = 0, pixel_x = 0, pixel_y = 0
  - hsync = 1, vsync = 1, video_on = 1
  - pixel_tick = 0 (if CLK_DIV = 1, pixel_tick = 1)
  - frame_end = 0
- After reset deassertion:
  - pixel_tick first rises after CLK_DIV-1 clk edges.
  - pixel_x first becomes 1 on the CLK_DIV-th edge.
- Latency from count to outputs: 0 cycles relative to pixel_x/pixel_y. All outputs change on the same clk edge.
- Line period = 800 ticks = 3200 clks. Frame period = 420000 ticks = 1 680 000 clks at CLK_DIV = 4.
- hsync low width = 96 ticks = 384 clks. vsync low width = 2 lines = 6400 clks.
- frame_end is high for exactly one clk per frame. It coincides with pixel_tick.

## Test plan
- Reset: assert reset mid-stream at (300, 200) → pixel_x/pixel_y become 0 and hsync = vsync = video_on = 1 without waiting for a clk edge. After release, first pixel_tick occurs on the 3rd clk, and pixel_x = 1 after the 4th.
- Tick cadence: run 40 clks → pixel_tick is high on exactly 10 clks, spaced 4 apart, and pixel_x increments only on those edges.
- Horizontal timing on line 0:
  - video_on falls when pixel_x goes 639→640.
  - hsync falls at pixel_x = 656 and rises at 752; it is low for exactly 384 clks.
  - pixel_x wraps 799→0 while pixel_y goes 0→1 on the same edge.
- Vertical timing:
  - vsync is low only while pixel_y is 490..491.
  - video_on stays 0 for all of lines 480..524.
  - At (799, 524), frame_end pulses for one clk, then the counters read (0, 0).
- Frame length: count clks between consecutive frame_end pulses → 1 680 000. With CLK_DIV = 1, the same measurement gives 420 000 and pixel_tick is always 1.
- Consistency check over a full frame: on every clk, hsync, vsync and video_on equal the decode formulas applied to the currently presented pixel_x/pixel_y. No mismatch is allowed.
